// File: rtl/terminal_console_pkg.sv
// Shared constants for the terminal console: screen geometry, control codes
// and the sequencer state encoding.
package terminal_console_pkg;

   localparam int TERM_COLUMNS = 80;
   localparam int TERM_ROWS    = 30;

   localparam logic [7:0] CHAR_BS    = 8'h08;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_FF    = 8'h0C;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PUT        = 3'd1,
      ST_ERASE      = 3'd2,
      ST_SCROLL_RD  = 3'd3,
      ST_SCROLL_WR  = 3'd4,
      ST_CLEAR_LINE = 3'd5,
      ST_CLEAR_ALL  = 3'd6
   } state_t;

endpackage

// File: rtl/terminal_console.sv
// Character stream to Terminal text RAM writer: cursor tracking, control codes,
// hardware scroll via the text read port and full-screen clear.
module terminal_console
   import terminal_console_pkg::*;
#(
   parameter int COLUMNS    = TERM_COLUMNS,
   parameter int ROWS       = TERM_ROWS,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            char_data,
   input  logic                  char_valid,
   output logic                  char_ready,
   output logic [ADDR_WIDTH-1:0] text_addr,
   input  logic [7:0]            text_read_data,
   output logic                  text_write,
   output logic [7:0]            text_write_data,
   output logic [4:0]            cursor_row,
   output logic [6:0]            cursor_col,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH-1:0] L_COLS       = ADDR_WIDTH'(COLUMNS);
   localparam logic [ADDR_WIDTH-1:0] L_SCROLL_END = ADDR_WIDTH'((ROWS-1)*COLUMNS-1);
   localparam logic [ADDR_WIDTH-1:0] L_LAST_BASE  = ADDR_WIDTH'((ROWS-1)*COLUMNS);
   localparam logic [ADDR_WIDTH-1:0] L_SCREEN_END = ADDR_WIDTH'(ROWS*COLUMNS-1);
   localparam logic [4:0]            L_LAST_ROW   = 5'(ROWS-1);
   localparam logic [6:0]            L_LAST_COL   = 7'(COLUMNS-1);

   state_t                r_state;
   logic [4:0]            r_row;
   logic [6:0]            r_col;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [7:0]            r_byte;

   logic [ADDR_WIDTH-1:0] w_row_ext;
   logic [ADDR_WIDTH-1:0] w_row_base;
   logic [ADDR_WIDTH-1:0] w_cur_addr;

   assign w_row_ext = ADDR_WIDTH'(r_row);

   generate
      if (COLUMNS == 80) begin : g_shift_add
         assign w_row_base = (w_row_ext << 6) + (w_row_ext << 4);
      end else begin : g_const_mul
         assign w_row_base = w_row_ext * L_COLS;
      end
   endgenerate

   assign w_cur_addr = w_row_base + ADDR_WIDTH'(r_col);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_cnt   <= '0;
         r_byte  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (char_valid) begin
                  r_byte <= char_data;
                  if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                     r_state <= ST_PUT;
                  end else begin
                     case (char_data)
                        CHAR_CR: r_col <= '0;
                        CHAR_LF: begin
                           r_col <= '0;
                           if (r_row < L_LAST_ROW) begin
                              r_row <= r_row + 5'd1;
                           end else begin
                              r_cnt   <= '0;
                              r_state <= ST_SCROLL_RD;
                           end
                        end
                        CHAR_BS: begin
                           if (r_col != '0) begin
                              r_col   <= r_col - 7'd1;
                              r_state <= ST_ERASE;
                           end
                        end
                        CHAR_FF: begin
                           r_cnt   <= '0;
                           r_state <= ST_CLEAR_ALL;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            ST_PUT: begin
               if (r_col < L_LAST_COL) begin
                  r_col   <= r_col + 7'd1;
                  r_state <= ST_IDLE;
               end else begin
                  r_col <= '0;
                  if (r_row < L_LAST_ROW) begin
                     r_row   <= r_row + 5'd1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= ST_SCROLL_RD;
                  end
               end
            end
            ST_ERASE:     r_state <= ST_IDLE;
            ST_SCROLL_RD: r_state <= ST_SCROLL_WR;
            ST_SCROLL_WR: begin
               if (r_cnt == L_SCROLL_END) begin
                  r_cnt   <= L_LAST_BASE;
                  r_state <= ST_CLEAR_LINE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= ST_SCROLL_RD;
               end
            end
            ST_CLEAR_LINE: begin
               if (r_cnt == L_SCREEN_END) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_CLEAR_ALL: begin
               if (r_cnt == L_SCREEN_END) begin
                  r_cnt   <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Text port is decoded from registers only; the scroll write forwards the
   // RAM read data because it arrives one cycle after the read address.
   always_comb begin
      text_addr       = '0;
      text_write      = 1'b0;
      text_write_data = '0;
      case (r_state)
         ST_PUT: begin
            text_addr       = w_cur_addr;
            text_write      = 1'b1;
            text_write_data = r_byte;
         end
         ST_ERASE: begin
            text_addr       = w_cur_addr;
            text_write      = 1'b1;
            text_write_data = CHAR_SPACE;
         end
         ST_SCROLL_RD: text_addr = r_cnt + L_COLS;
         ST_SCROLL_WR: begin
            text_addr       = r_cnt;
            text_write      = 1'b1;
            text_write_data = text_read_data;
         end
         ST_CLEAR_LINE, ST_CLEAR_ALL: begin
            text_addr       = r_cnt;
            text_write      = 1'b1;
            text_write_data = CHAR_SPACE;
         end
         default: ;
      endcase
   end

   assign char_ready = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign cursor_row = r_row;
   assign cursor_col = r_col;

endmodule

// File: tb/tb_terminal_console.sv
// Scoreboard bench for terminal_console with a behavioural Terminal text RAM.
module tb_terminal_console;

   localparam int COLS   = 80;
   localparam int NROWS  = 30;
   localparam int AW     = 12;
   localparam int SCREEN = COLS * NROWS;
   localparam int LIMIT  = 20000;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    char_data = '0;
   logic          char_valid = 1'b0;
   logic          char_ready;
   logic [AW-1:0] text_addr;
   logic [7:0]    text_read_data = '0;
   logic          text_write;
   logic [7:0]    text_write_data;
   logic [4:0]    cursor_row;
   logic [6:0]    cursor_col;
   logic          busy;

   logic [7:0]    mem  [0:4095];
   logic [7:0]    snap [0:4095];
   logic          pl_we = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [7:0]    pl_data = '0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;
   wr_t sb_q[$];
   wr_t sb_e;
   bit  sb_en = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   terminal_console #(
      .COLUMNS(COLS),
      .ROWS(NROWS),
      .ADDR_WIDTH(AW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .char_data(char_data),
      .char_valid(char_valid),
      .char_ready(char_ready),
      .text_addr(text_addr),
      .text_read_data(text_read_data),
      .text_write(text_write),
      .text_write_data(text_write_data),
      .cursor_row(cursor_row),
      .cursor_col(cursor_col),
      .busy(busy)
   );

   always @(posedge clock) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (text_write) mem[text_addr] <= text_write_data;
      text_read_data <= mem[text_addr];
   end

   always @(negedge clock) begin
      if (sb_en && reset && text_write) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_write: addr=%0d data=%02h, required no write", text_addr, text_write_data);
         end else begin
            sb_e = sb_q.pop_front();
            if (text_addr !== sb_e.addr || text_write_data !== sb_e.data) begin
               n_fail++;
               $display("FAIL sb_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        text_addr, text_write_data, sb_e.addr, sb_e.data);
            end
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic push(input int a, input logic [7:0] d);
      wr_t w;
      w.addr = AW'(a);
      w.data = d;
      sb_q.push_back(w);
   endtask

   task automatic do_reset();
      char_valid = 1'b0;
      reset = 1'b0;
      sb_q.delete();
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   // Returns the number of cycles char_ready stayed low after the accepting edge.
   task automatic send(input logic [7:0] b, output int busy_n);
      int g;
      g = 0;
      @(negedge clock);
      while (!char_ready && g < LIMIT) begin
         g++;
         @(negedge clock);
      end
      char_data  = b;
      char_valid = 1'b1;
      @(posedge clock);
      #1;
      char_valid = 1'b0;
      busy_n = 0;
      while (!char_ready && busy_n < LIMIT) begin
         busy_n++;
         @(posedge clock);
         #1;
      end
      if (g >= LIMIT || busy_n >= LIMIT) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: byte=%02h wait=%0d busy=%0d, required < %0d", b, g, busy_n, LIMIT);
      end
   endtask

   task automatic move_to(input int r, input int c, input logic [7:0] ch);
      int n;
      for (int i = 0; i < r; i++) send(8'h0A, n);
      for (int j = 0; j < c; j++) begin
         push(r * COLS + j, ch);
         send(ch, n);
      end
   endtask

   task automatic push_scroll_from_snap();
      for (int i = 0; i < SCREEN - COLS; i++) push(i, snap[i + COLS]);
      for (int i = SCREEN - COLS; i < SCREEN; i++) push(i, 8'h20);
   endtask

   task automatic check_cursor(input string name, input int r, input int c);
      n_tests++;
      if (cursor_row !== 5'(r) || cursor_col !== 7'(c)) begin
         n_fail++;
         $display("FAIL %s: cursor=(%0d,%0d), required (%0d,%0d)", name, cursor_row, cursor_col, r, c);
      end
   endtask

   task automatic check_sb_empty(input string name);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d expected writes missing, required 0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      n_tests++;
      if ({char_ready, text_write, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_flags: ready/write/busy=%b, required 100", {char_ready, text_write, busy});
      end
      n_tests++;
      if (text_addr !== '0 || text_write_data !== '0) begin
         n_fail++;
         $display("FAIL reset_text: addr=%0d data=%02h, required 0/00", text_addr, text_write_data);
      end
      check_cursor("reset_cursor", 0, 0);
      do_reset();
   endtask

   task automatic test_put();
      int n;
      do_reset();
      push(0, 8'h41);
      push(1, 8'h42);
      send(8'h41, n);
      n_tests++;
      if (n !== 1) begin n_fail++; $display("FAIL put_A_busy: %0d cycles, required 1", n); end
      send(8'h42, n);
      n_tests++;
      if (n !== 1) begin n_fail++; $display("FAIL put_B_busy: %0d cycles, required 1", n); end
      check_cursor("put_cursor", 0, 2);
      check_sb_empty("put_sb");
   endtask

   task automatic test_full_row();
      int n, bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < COLS; i++) begin
         push(i, 8'h78);
         send(8'h78, n);
         if (n != 1) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL row_busy: %0d chars not 1 cycle, required 0", bad); end
      check_cursor("row_cursor", 1, 0);
      check_sb_empty("row_sb");
   endtask

   task automatic test_scroll_lf();
      int n, bad_q, bad_sp;
      do_reset();
      for (int i = 0; i < SCREEN; i++) begin
         @(negedge clock);
         pl_we   = 1'b1;
         pl_addr = AW'(i);
         pl_data = (i >= COLS && i < 2 * COLS) ? 8'h51 : 8'(8'h21 + (i % 90));
      end
      @(negedge clock);
      pl_we = 1'b0;
      move_to(29, 5, 8'h7A);
      for (int i = 0; i < SCREEN; i++) snap[i] = mem[i];
      push_scroll_from_snap();
      send(8'h0A, n);
      n_tests++;
      if (n !== 4720) begin n_fail++; $display("FAIL scroll_busy: %0d cycles, required 4720", n); end
      check_cursor("scroll_cursor", 29, 0);
      check_sb_empty("scroll_sb");
      bad_q = 0;
      bad_sp = 0;
      for (int i = 0; i < COLS; i++) if (mem[i] !== 8'h51) bad_q++;
      for (int i = SCREEN - COLS; i < SCREEN; i++) if (mem[i] !== 8'h20) bad_sp++;
      n_tests++;
      if (bad_q != 0) begin n_fail++; $display("FAIL scroll_row0: %0d cells not 51, required 0", bad_q); end
      n_tests++;
      if (bad_sp != 0) begin n_fail++; $display("FAIL scroll_lastrow: %0d cells not 20, required 0", bad_sp); end
   endtask

   task automatic test_wrap_scroll();
      int n;
      do_reset();
      move_to(29, 79, 8'h77);
      for (int i = 0; i < SCREEN; i++) snap[i] = mem[i];
      snap[SCREEN - 1] = 8'h45;
      push(SCREEN - 1, 8'h45);
      push_scroll_from_snap();
      send(8'h45, n);
      n_tests++;
      if (n !== 4721) begin n_fail++; $display("FAIL wrap_busy: %0d cycles, required 4721", n); end
      check_cursor("wrap_cursor", 29, 0);
      check_sb_empty("wrap_sb");
   endtask

   task automatic test_backspace();
      int n;
      do_reset();
      move_to(3, 10, 8'h62);
      push(3 * COLS + 9, 8'h20);
      send(8'h08, n);
      n_tests++;
      if (n !== 1) begin n_fail++; $display("FAIL bs_busy: %0d cycles, required 1", n); end
      check_cursor("bs_cursor", 3, 9);
      send(8'h0D, n);
      check_cursor("cr_cursor", 3, 0);
      send(8'h08, n);
      n_tests++;
      if (n !== 0) begin n_fail++; $display("FAIL bs_col0_busy: %0d cycles, required 0", n); end
      check_cursor("bs_col0_cursor", 3, 0);
      check_sb_empty("bs_sb");
   endtask

   task automatic test_clear();
      int n;
      for (int i = 0; i < SCREEN; i++) push(i, 8'h20);
      send(8'h0C, n);
      n_tests++;
      if (n !== 2400) begin n_fail++; $display("FAIL clear_busy: %0d cycles, required 2400", n); end
      check_cursor("clear_cursor", 0, 0);
      n_tests++;
      if (char_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready: %b, required 1", char_ready); end
      check_sb_empty("clear_sb");
      send(8'h0D, n);
      send(8'h07, n);
      n_tests++;
      if (n !== 0) begin n_fail++; $display("FAIL bell_busy: %0d cycles, required 0", n); end
      repeat (2) @(negedge clock);
      check_sb_empty("ignore_sb");
   endtask

   task automatic test_reset_mid_scroll();
      do_reset();
      move_to(29, 0, 8'h20);
      sb_en = 1'b0;
      @(negedge clock);
      char_data  = 8'h0A;
      char_valid = 1'b1;
      @(posedge clock);
      #1;
      char_valid = 1'b0;
      repeat (100) @(posedge clock);
      #3;
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL midscroll_busy: %b, required 1", busy); end
      reset = 1'b0;
      #1;
      n_tests++;
      if (text_write !== 1'b0 || char_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_outputs: write=%b ready=%b, required 0/1", text_write, char_ready);
      end
      @(negedge clock);
      reset = 1'b1;
      sb_q.delete();
      sb_en = 1'b1;
      @(posedge clock);
      #1;
      check_cursor("abort_cursor", 0, 0);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: %b, required 0", busy); end
   endtask

   initial begin
      test_reset();
      test_put();
      test_full_row();
      test_scroll_lf();
      test_wrap_scroll();
      test_backspace();
      test_clear();
      test_reset_mid_scroll();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
